lapido_scoreboard: RTL

LAPIDO_SCOREBOARD -- requirements
Module: lapido_scoreboard

---
 rtl/lapido_scoreboard_pkg.sv | 31 +++
 rtl/lapido_scoreboard_if.sv | 31 +++
 rtl/lapido_scoreboard_entry.sv | 108 ++++++++++
 rtl/lapido_scoreboard.sv | 107 ++++++++++
 4 files changed

// File: rtl/lapido_scoreboard_pkg.sv
// Shared definitions for the lapido GPR scoreboard: default sizing,
// per-entry operation encoding and small helper functions.
package lapido_scoreboard_pkg;

    // Default sizing of the tracked register file and timing window.
    localparam int LAPIDO_NUM_REGS    = 32;
    localparam int GRP_ADDR_WIDTH     = $clog2(LAPIDO_NUM_REGS);
    localparam int LAPIDO_NUM_SRC     = 2;
    localparam int LAPIDO_LAT_MAX     = 7;
    localparam int LAPIDO_FLUSH_DEPTH = 2;

    // Operation applied to one scoreboard entry on the next clock edge.
    typedef enum logic [1:0] {
        ENTRY_HOLD  = 2'd0,
        ENTRY_LOAD  = 2'd1,
        ENTRY_FLUSH = 2'd2,
        ENTRY_DEC   = 2'd3
    } entry_op_e;

    // Width of a countdown able to hold 0..lat_max.
    function automatic int lat_width(input int lat_max);
        return $clog2(lat_max + 1);
    endfunction

    // A register index takes part in hazard tracking unless it is the
    // hardwired zero register.
    function automatic logic reg_tracked(input int reg_idx, input int zero_hw);
        return (zero_hw == 0) || (reg_idx != 0);
    endfunction

endpackage

// File: rtl/lapido_scoreboard_if.sv
// Decode-stage <-> scoreboard handshake bundle. The decode stage is the
// master (presents the instruction), the scoreboard is the slave.
interface lapido_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 3
);
    logic                      issue_valid;
    logic                      issue_we;
    logic [ADDR_W-1:0]         issue_dst;
    logic [LAT_W-1:0]          issue_lat;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic                      flush;
    logic                      stall;
    logic                      issue_ok;
    logic [ADDR_W:0]           pending_cnt;
    logic [31:0]               stall_cycles;

    modport master (
        output issue_valid, issue_we, issue_dst, issue_lat,
               src_addr, src_used, flush,
        input  stall, issue_ok, pending_cnt, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_we, issue_dst, issue_lat,
               src_addr, src_used, flush,
        output stall, issue_ok, pending_cnt, stall_cycles
    );
endinterface

// File: rtl/lapido_scoreboard_entry.sv
// One scoreboard entry (lapido_sb_entry): tracks whether a GPR has an
// in-flight write, how many cycles remain until it is forwardable, and how
// long ago it was issued so that a flush can cancel only young writes.
module lapido_sb_entry
    import lapido_scoreboard_pkg::*;
#(
    parameter int LAT_W       = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_cnt,
    input  logic             flush,
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);
    localparam int AGE_W = $clog2(FLUSH_DEPTH + 1);

    logic             busy_r;
    logic [LAT_W-1:0] cnt_r;
    logic [AGE_W-1:0] age_r;

    logic             young_s;
    entry_op_e        op_s;
    logic             busy_nxt_s;
    logic [LAT_W-1:0] cnt_nxt_s;
    logic [AGE_W-1:0] age_nxt_s;

    assign young_s = (age_r < AGE_W'(FLUSH_DEPTH));

    // Select the entry operation: a flush of a young write wins over
    // everything, then a new issue, then the normal countdown.
    always_comb begin
        op_s = ENTRY_HOLD;
        if (flush && busy_r && young_s) begin
            op_s = ENTRY_FLUSH;
        end else if (load) begin
            op_s = ENTRY_LOAD;
        end else if (busy_r) begin
            op_s = ENTRY_DEC;
        end else begin
            op_s = ENTRY_HOLD;
        end
    end

    // Compute the next busy/count/age values for the selected operation.
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        age_nxt_s  = age_r;
        case (op_s)
            ENTRY_LOAD: begin
                busy_nxt_s = 1'b1;
                cnt_nxt_s  = load_cnt;
                age_nxt_s  = AGE_W'(0);
            end
            ENTRY_FLUSH: begin
                busy_nxt_s = 1'b0;
                cnt_nxt_s  = LAT_W'(0);
                age_nxt_s  = AGE_W'(0);
            end
            ENTRY_DEC: begin
                if (cnt_r <= LAT_W'(1)) begin
                    // Result becomes forwardable on this edge.
                    busy_nxt_s = 1'b0;
                    cnt_nxt_s  = LAT_W'(0);
                    age_nxt_s  = AGE_W'(0);
                end else begin
                    busy_nxt_s = 1'b1;
                    cnt_nxt_s  = cnt_r - LAT_W'(1);
                    if (age_r == AGE_W'(FLUSH_DEPTH)) begin
                        age_nxt_s = age_r;
                    end else begin
                        age_nxt_s = age_r + AGE_W'(1);
                    end
                end
            end
            ENTRY_HOLD: begin
                busy_nxt_s = busy_r;
                cnt_nxt_s  = cnt_r;
                age_nxt_s  = age_r;
            end
            default: begin
                busy_nxt_s = 1'b0;
                cnt_nxt_s  = LAT_W'(0);
                age_nxt_s  = AGE_W'(0);
            end
        endcase
    end

    // Entry state register; reset drops any pending write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            cnt_r  <= LAT_W'(0);
            age_r  <= AGE_W'(0);
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
            age_r  <= age_nxt_s;
        end
    end

    assign busy = busy_r;
    assign cnt  = cnt_r;

endmodule

// File: rtl/lapido_scoreboard.sv
// lapido_scoreboard: GPR in-flight write tracker for an in-order pipeline.
// Detects RAW and WAW hazards for the instruction in decode, records newly
// issued writes with their latency, cancels young writes on a flush and
// counts stalled cycles.
module lapido_scoreboard
    import lapido_scoreboard_pkg::*;
#(
    parameter int NUM_REGS       = LAPIDO_NUM_REGS,
    parameter int ADDR_W         = $clog2(NUM_REGS),
    parameter int NUM_SRC        = LAPIDO_NUM_SRC,
    parameter int LAT_MAX        = LAPIDO_LAT_MAX,
    parameter int FLUSH_DEPTH    = LAPIDO_FLUSH_DEPTH,
    parameter int ZERO_HARDWIRED = 1,
    localparam int LAT_W         = lat_width(LAT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    lapido_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] busy_s;
    logic [LAT_W-1:0]    cnt_s [NUM_REGS];
    logic [NUM_REGS-1:0] load_s;

    logic                raw_s;
    logic                waw_s;
    logic                stall_s;
    logic                issue_ok_s;
    logic                dst_tracked_s;
    logic                accept_write_s;
    logic [ADDR_W:0]     pending_s;
    logic [31:0]         stall_cycles_r;

    // RAW/WAW hazard detection against the state before this cycle's update.
    always_comb begin
        raw_s = 1'b0;
        waw_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                raw_s = raw_s | (sb.src_used[i] & busy_s[r]
                                 & (sb.src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
                                 & reg_tracked(r, ZERO_HARDWIRED));
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            waw_s = waw_s | (sb.issue_we & busy_s[r]
                             & (sb.issue_dst == ADDR_W'(r))
                             & (cnt_s[r] > sb.issue_lat)
                             & reg_tracked(r, ZERO_HARDWIRED));
        end
    end

    assign stall_s    = sb.issue_valid & (raw_s | waw_s);
    assign issue_ok_s = sb.issue_valid & ~stall_s & ~sb.flush;

    // Only accepted, latency-bearing writes to a tracked register are recorded.
    assign dst_tracked_s  = (ZERO_HARDWIRED == 0) || (sb.issue_dst != ADDR_W'(0));
    assign accept_write_s = issue_ok_s & sb.issue_we
                            & (sb.issue_lat != LAT_W'(0)) & dst_tracked_s;

    // Decode the destination into a one-hot load strobe for the entries.
    always_comb begin
        load_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            load_s[r] = accept_write_s & (sb.issue_dst == ADDR_W'(r));
        end
    end

    // Population count of in-flight writes.
    always_comb begin
        pending_s = (ADDR_W+1)'(0);
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_s = pending_s + (ADDR_W+1)'(busy_s[r]);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        lapido_sb_entry #(
            .LAT_W       (LAT_W),
            .FLUSH_DEPTH (FLUSH_DEPTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load_s[g]),
            .load_cnt (sb.issue_lat),
            .flush    (sb.flush),
            .busy     (busy_s[g]),
            .cnt      (cnt_s[g])
        );
    end

    // Saturating count of cycles where decode was held by a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s && !sb.flush && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign sb.stall        = stall_s;
    assign sb.issue_ok     = issue_ok_s;
    assign sb.pending_cnt  = pending_s;
    assign sb.stall_cycles = stall_cycles_r;

endmodule
